// File: rtl/sram_rr_scheduler_if.sv
// sram_rr_scheduler_if
// Bundles the requester ports and the SRAM controller command/return signals
// of sram_rr_scheduler.
//   slave  : scheduler view (request valids/data in, readies out, command out,
//            read return in, read data and status out)
//   master : environment view (requesters plus SRAM controller), mirror of slave
// Ports carried:
//   w0/w1_din_valid, w0/w1_din_ready, w0/w1_din {mask, addr, data}
//   r0/r1_din_valid, r0/r1_din_ready, r0/r1_din (address)
//   r0/r1_dout_valid, r0/r1_dout (read data, one-cycle pulse)
//   sram_addr_valid, sram_ready, sram_addr, sram_data_in, sram_write_mask
//   sram_data_out, sram_data_out_valid, tag_count, err_underflow
interface sram_rr_scheduler_if #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 8
);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic                       w0_din_valid;
    logic                       w0_din_ready;
    logic [4+ADDR_W+DATA_W-1:0] w0_din;
    logic                       w1_din_valid;
    logic                       w1_din_ready;
    logic [4+ADDR_W+DATA_W-1:0] w1_din;
    logic                       r0_din_valid;
    logic                       r0_din_ready;
    logic [ADDR_W-1:0]          r0_din;
    logic                       r1_din_valid;
    logic                       r1_din_ready;
    logic [ADDR_W-1:0]          r1_din;
    logic                       r0_dout_valid;
    logic [DATA_W-1:0]          r0_dout;
    logic                       r1_dout_valid;
    logic [DATA_W-1:0]          r1_dout;
    logic                       sram_addr_valid;
    logic                       sram_ready;
    logic [ADDR_W-1:0]          sram_addr;
    logic [DATA_W-1:0]          sram_data_in;
    logic [3:0]                 sram_write_mask;
    logic [DATA_W-1:0]          sram_data_out;
    logic                       sram_data_out_valid;
    logic [CNT_W-1:0]           tag_count;
    logic                       err_underflow;

    modport slave (
        input  w0_din_valid, w0_din, w1_din_valid, w1_din,
        input  r0_din_valid, r0_din, r1_din_valid, r1_din,
        input  sram_ready, sram_data_out, sram_data_out_valid,
        output w0_din_ready, w1_din_ready, r0_din_ready, r1_din_ready,
        output r0_dout_valid, r0_dout, r1_dout_valid, r1_dout,
        output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
        output tag_count, err_underflow
    );

    modport master (
        output w0_din_valid, w0_din, w1_din_valid, w1_din,
        output r0_din_valid, r0_din, r1_din_valid, r1_din,
        output sram_ready, sram_data_out, sram_data_out_valid,
        input  w0_din_ready, w1_din_ready, r0_din_ready, r1_din_ready,
        input  r0_dout_valid, r0_dout, r1_dout_valid, r1_dout,
        input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
        input  tag_count, err_underflow
    );
endinterface

// File: rtl/sram_rr_scheduler.sv
// sram_rr_scheduler
// Shares one ZBT SRAM controller between two writers (w0, w1) and two readers
// (r0, r1). Requests are arbitrated into a single registered command (CR) that
// drives the controller's ready/valid command port. Each issued read pushes the
// requester id into a tag FIFO; returned data pops it and is steered to the
// requester that issued the read.
// Ports:
//   clock  - single clock for all logic
//   reset  - asynchronous, active-high, clears all state
//   bus    - sram_rr_scheduler_if.slave (requesters, SRAM command/return,
//            tag_count, sticky err_underflow)
// Configuration:
//   SRAM_SCHED_READ_PRIORITY_EN - when defined, eligible reads always beat
//   eligible writes, with separate 1-bit round-robin pointers for reads and
//   writes. Undefined: plain 4-way round robin w0, r0, w1, r1.
module sram_rr_scheduler #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 8
) (
    input logic                clock,
    input logic                reset,
    sram_rr_scheduler_if.slave bus
);
    localparam int CNT_W  = $clog2(TAG_DEPTH) + 1;
    localparam int IDX_W  = $clog2(TAG_DEPTH);
    localparam int WREQ_W = 4 + ADDR_W + DATA_W;

    // Encoding doubles as the round-robin position.
    typedef enum logic [1:0] {REQ_W0 = 2'd0, REQ_R0 = 2'd1, REQ_W1 = 2'd2, REQ_R1 = 2'd3} req_e;

    logic                 cr_valid_q, cr_valid_d;
    logic [ADDR_W-1:0]    cr_addr_q, cr_addr_d;
    logic [DATA_W-1:0]    cr_data_q, cr_data_d;
    logic [3:0]           cr_mask_q, cr_mask_d;
`ifdef SRAM_SCHED_READ_PRIORITY_EN
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
`else
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [1:0]           idx;
`endif
    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [IDX_W-1:0]     tag_wr_q, tag_wr_d;
    logic [IDX_W-1:0]     tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0]     tag_count_q, tag_count_d;
    logic                 r0_dout_valid_q, r0_dout_valid_d;
    logic                 r1_dout_valid_q, r1_dout_valid_d;
    logic [DATA_W-1:0]    r0_dout_q, r0_dout_d;
    logic [DATA_W-1:0]    r1_dout_q, r1_dout_d;
    logic                 err_q, err_d;

    logic                 cr_open;
    logic                 tag_full;
    logic [3:0]           elig;
    logic [3:0]           gnt;
    logic                 gnt_any;
    req_e                 gnt_id;
    logic [WREQ_W-1:0]    wreq;
    logic [3:0]           wmask;
    logic                 push, pop, push_id, pop_id;

    // Arbitration: the CR can take a new command when empty or draining now.
    // elig bit index equals the req_e encoding.
    always_comb begin
        tag_full = (tag_count_q == CNT_W'(TAG_DEPTH));
        cr_open  = !cr_valid_q || bus.sram_ready;
        elig     = {bus.r1_din_valid & !tag_full, bus.w1_din_valid,
                    bus.r0_din_valid & !tag_full, bus.w0_din_valid};
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_id   = REQ_W0;
`ifdef SRAM_SCHED_READ_PRIORITY_EN
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (cr_open) begin
            if (elig[1] || elig[3]) begin
                gnt_any  = 1'b1;
                gnt_id   = (elig[1] && (!rd_ptr_q || !elig[3])) ? REQ_R0 : REQ_R1;
                rd_ptr_d = (gnt_id == REQ_R0);
            end else if (elig[0] || elig[2]) begin
                gnt_any  = 1'b1;
                gnt_id   = (elig[0] && (!wr_ptr_q || !elig[2])) ? REQ_W0 : REQ_W1;
                wr_ptr_d = (gnt_id == REQ_W0);
            end
        end
`else
        rr_ptr_d = rr_ptr_q;
        idx      = rr_ptr_q;
        if (cr_open) begin
            for (int k = 0; k < 4; k++) begin
                idx = rr_ptr_q + 2'(k);
                if (!gnt_any && elig[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = req_e'(idx);
                end
            end
        end
        if (gnt_any) rr_ptr_d = 2'(gnt_id) + 2'd1;
`endif
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

    assign bus.w0_din_ready = gnt[0];
    assign bus.r0_din_ready = gnt[1];
    assign bus.w1_din_ready = gnt[2];
    assign bus.r1_din_ready = gnt[3];

    // Command register load. A zero write mask would look like a read to the
    // controller, so it is promoted to a full-word write.
    always_comb begin
        cr_valid_d = cr_valid_q && !bus.sram_ready;
        cr_addr_d  = cr_addr_q;
        cr_data_d  = cr_data_q;
        cr_mask_d  = cr_mask_q;
        wreq       = (gnt_id == REQ_W1) ? bus.w1_din : bus.w0_din;
        wmask      = wreq[WREQ_W-1 -: 4];
        if (gnt_any) begin
            cr_valid_d = 1'b1;
            case (gnt_id)
                REQ_R0: begin
                    cr_addr_d = bus.r0_din;
                    cr_data_d = '0;
                    cr_mask_d = 4'b0000;
                end
                REQ_R1: begin
                    cr_addr_d = bus.r1_din;
                    cr_data_d = '0;
                    cr_mask_d = 4'b0000;
                end
                default: begin
                    cr_addr_d = wreq[ADDR_W+DATA_W-1 -: ADDR_W];
                    cr_data_d = wreq[DATA_W-1:0];
                    cr_mask_d = (wmask == 4'b0000) ? 4'b1111 : wmask;
                end
            endcase
        end
    end

    // Tag FIFO and read return steering. A return with no outstanding tag is
    // dropped and latched as a sticky error.
    always_comb begin
        push            = gnt_any && (gnt_id == REQ_R0 || gnt_id == REQ_R1);
        push_id         = (gnt_id == REQ_R1);
        pop             = bus.sram_data_out_valid && (tag_count_q != '0);
        pop_id          = tag_mem_q[tag_rd_q];
        tag_mem_d       = tag_mem_q;
        tag_wr_d        = tag_wr_q;
        tag_rd_d        = tag_rd_q;
        if (push) begin
            tag_mem_d[tag_wr_q] = push_id;
            tag_wr_d            = tag_wr_q + IDX_W'(1);
        end
        if (pop) tag_rd_d = tag_rd_q + IDX_W'(1);
        tag_count_d     = tag_count_q + CNT_W'(push) - CNT_W'(pop);
        r0_dout_valid_d = pop && !pop_id;
        r1_dout_valid_d = pop && pop_id;
        r0_dout_d       = (pop && !pop_id) ? bus.sram_data_out : r0_dout_q;
        r1_dout_d       = (pop && pop_id) ? bus.sram_data_out : r1_dout_q;
        err_d           = err_q || (bus.sram_data_out_valid && (tag_count_q == '0));
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cr_valid_q      <= 1'b0;
            cr_addr_q       <= '0;
            cr_data_q       <= '0;
            cr_mask_q       <= '0;
`ifdef SRAM_SCHED_READ_PRIORITY_EN
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
`else
            rr_ptr_q        <= 2'd0;
`endif
            tag_mem_q       <= '0;
            tag_wr_q        <= '0;
            tag_rd_q        <= '0;
            tag_count_q     <= '0;
            r0_dout_valid_q <= 1'b0;
            r1_dout_valid_q <= 1'b0;
            r0_dout_q       <= '0;
            r1_dout_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            cr_valid_q      <= cr_valid_d;
            cr_addr_q       <= cr_addr_d;
            cr_data_q       <= cr_data_d;
            cr_mask_q       <= cr_mask_d;
`ifdef SRAM_SCHED_READ_PRIORITY_EN
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
`else
            rr_ptr_q        <= rr_ptr_d;
`endif
            tag_mem_q       <= tag_mem_d;
            tag_wr_q        <= tag_wr_d;
            tag_rd_q        <= tag_rd_d;
            tag_count_q     <= tag_count_d;
            r0_dout_valid_q <= r0_dout_valid_d;
            r1_dout_valid_q <= r1_dout_valid_d;
            r0_dout_q       <= r0_dout_d;
            r1_dout_q       <= r1_dout_d;
            err_q           <= err_d;
        end
    end

    assign bus.sram_addr_valid = cr_valid_q;
    assign bus.sram_addr       = cr_addr_q;
    assign bus.sram_data_in    = cr_data_q;
    assign bus.sram_write_mask = cr_mask_q;
    assign bus.tag_count       = tag_count_q;
    assign bus.err_underflow   = err_q;
    assign bus.r0_dout_valid   = r0_dout_valid_q;
    assign bus.r1_dout_valid   = r1_dout_valid_q;
    assign bus.r0_dout         = r0_dout_q;
    assign bus.r1_dout         = r1_dout_q;
endmodule

// File: tb/tb_sram_rr_scheduler.sv
// tb_sram_rr_scheduler
// Self-checking bench for sram_rr_scheduler. Inputs change on the falling
// edge; combinational readies are sampled 2 ns later, registered outputs 1 ns
// after the rising edge. Issued commands and read tags go into scoreboard
// queues and are popped when the controller accepts a command or returns data.
module tb_sram_rr_scheduler;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 32;
    localparam int TAG_DEPTH = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        mask;
    } cmd_t;

    typedef struct packed {
        logic       w0v, r0v, w1v, r1v, rdy;
        logic [3:0] exp_gnt;   // {r1, w1, r0, w0}
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_rr_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) bus();

    sram_rr_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    cmd_t cmd_q[$];
    logic tag_q[$];
    logic model_cr_valid;
    int   model_count;
    logic model_err;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic w0v, input logic r0v, input logic w1v,
                           input logic r1v, input logic rdy);
        bus.w0_din_valid        = w0v;
        bus.r0_din_valid        = r0v;
        bus.w1_din_valid        = w1v;
        bus.r1_din_valid        = r1v;
        bus.sram_ready          = rdy;
        bus.w0_din              = {4'($urandom_range(0, 15)), ADDR_W'($urandom), DATA_W'($urandom)};
        bus.w1_din              = {4'($urandom_range(0, 15)), ADDR_W'($urandom), DATA_W'($urandom)};
        bus.r0_din              = ADDR_W'($urandom);
        bus.r1_din              = ADDR_W'($urandom);
        bus.sram_data_out_valid = 1'b0;
        bus.sram_data_out       = DATA_W'($urandom);
    endtask

    function automatic cmd_t wcmd(input logic [4+ADDR_W+DATA_W-1:0] din);
        cmd_t c;
        c.mask = din[4+ADDR_W+DATA_W-1 -: 4];
        if (c.mask == 4'b0000) c.mask = 4'b1111;
        c.addr = din[ADDR_W+DATA_W-1 -: ADDR_W];
        c.data = din[DATA_W-1:0];
        return c;
    endfunction

    // One clock cycle: called and returns on a falling edge.
    task automatic applyStimulus(input logic [3:0] exp_gnt);
        cmd_t        c;
        logic        next_valid;
        logic        pop_ok;
        logic        pop_id;
        logic [DATA_W-1:0] ret;
        pop_ok = 1'b0;
        pop_id = 1'b0;
        #2;
        check("din_ready", 64'({bus.r1_din_ready, bus.w1_din_ready, bus.r0_din_ready, bus.w0_din_ready}),
              64'(exp_gnt));
        if (model_cr_valid && bus.sram_ready) begin
            if (cmd_q.size() == 0) begin
                check("cmd_scoreboard_nonempty", 64'(0), 64'(1));
            end else begin
                c = cmd_q.pop_front();
                check("sram_cmd", 64'({bus.sram_addr, bus.sram_data_in, bus.sram_write_mask}), 64'(c));
            end
        end
        next_valid = model_cr_valid && !bus.sram_ready;
        ret = bus.sram_data_out;
        if (bus.sram_data_out_valid) begin
            if (tag_q.size() > 0) begin
                pop_id = tag_q.pop_front();
                pop_ok = 1'b1;
                model_count--;
            end else begin
                model_err = 1'b1;
            end
        end
        if (exp_gnt[0]) cmd_q.push_back(wcmd(bus.w0_din));
        if (exp_gnt[2]) cmd_q.push_back(wcmd(bus.w1_din));
        if (exp_gnt[1]) begin
            cmd_q.push_back({bus.r0_din, DATA_W'(0), 4'b0000});
            tag_q.push_back(1'b0);
            model_count++;
        end
        if (exp_gnt[3]) begin
            cmd_q.push_back({bus.r1_din, DATA_W'(0), 4'b0000});
            tag_q.push_back(1'b1);
            model_count++;
        end
        if (exp_gnt != 4'b0000) next_valid = 1'b1;
        @(posedge clock);
        #1;
        model_cr_valid = next_valid;
        checkOutput(pop_ok, pop_id, ret);
        @(negedge clock);
    endtask

    task automatic checkOutput(input logic pop_ok, input logic pop_id, input logic [DATA_W-1:0] ret);
        check("sram_addr_valid", 64'(bus.sram_addr_valid), 64'(model_cr_valid));
        check("tag_count", 64'(bus.tag_count), 64'(model_count));
        check("err_underflow", 64'(bus.err_underflow), 64'(model_err));
        check("r0_dout_valid", 64'(bus.r0_dout_valid), 64'(pop_ok && !pop_id));
        check("r1_dout_valid", 64'(bus.r1_dout_valid), 64'(pop_ok && pop_id));
        if (pop_ok && !pop_id) check("r0_dout", 64'(bus.r0_dout), 64'(ret));
        if (pop_ok && pop_id)  check("r1_dout", 64'(bus.r1_dout), 64'(ret));
    endtask

    // Reset with all inputs idle; clears the bench model. Returns on a falling edge.
    task automatic do_reset();
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cmd_q.delete();
        tag_q.delete();
        model_cr_valid = 1'b0;
        model_count    = 0;
        model_err      = 1'b0;
        @(negedge clock);
        #1;
        check("rst_outputs", 64'({bus.sram_addr_valid, bus.r0_dout_valid, bus.r1_dout_valid,
                                  bus.w0_din_ready, bus.w1_din_ready, bus.r0_din_ready,
                                  bus.r1_din_ready, bus.err_underflow}), 64'(0));
        check("rst_cmd", 64'({bus.sram_addr, bus.sram_data_in, bus.sram_write_mask}), 64'(0));
        check("rst_dout", 64'({bus.r0_dout, bus.r1_dout}), 64'(0));
        check("rst_tag_count", 64'(bus.tag_count), 64'(0));
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            applyStimulus(4'b0000);
        end

`ifdef SRAM_SCHED_READ_PRIORITY_EN
        // Reads beat writes; w0 only wins once r0 drops.
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            applyStimulus(4'b0010);
        end
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001);
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000);
`else
        // Round robin, stalls and empty-CR loads.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0010};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0010};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100};
        for (int i = 0; i < 14; i++) begin
            set_req(vecs[i].w0v, vecs[i].r0v, vecs[i].w1v, vecs[i].r1v, vecs[i].rdy);
            applyStimulus(vecs[i].exp_gnt);
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000);

        // Controller stall for 5 cycles with the CR full.
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001);
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            applyStimulus(4'b0000);
            check("stall_stable", 64'({bus.sram_addr, bus.sram_data_in, bus.sram_write_mask}),
                  64'(cmd_q[0]));
        end
        set_req(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b0010);
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000);

        // Drain the five outstanding reads, then one return too many.
        for (int i = 0; i < 6; i++) begin
            set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            bus.sram_data_out_valid = 1'b1;
            applyStimulus(4'b0000);
        end
        for (int i = 0; i < 2; i++) begin
            set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            applyStimulus(4'b0000);
        end

        // Fill the tag FIFO; reads then blocked while w0 keeps going.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            applyStimulus(4'b0010);
            set_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            applyStimulus(4'b1000);
        end
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            applyStimulus(4'b0001);
        end
        set_req(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.sram_data_out_valid = 1'b1;
        bus.sram_data_out       = 32'hDEADBEEF;
        applyStimulus(4'b0001);
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0010);

        // Zero write mask is promoted to a full-word write.
        set_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.w1_din = {4'b0000, 18'h00010, 32'h12345678};
        applyStimulus(4'b0100);
        check("mask0_write_mask", 64'(bus.sram_write_mask), 64'(4'b1111));
        check("mask0_addr", 64'(bus.sram_addr), 64'(18'h00010));
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000);

        // Reset with reads outstanding; a late return is an underflow.
        do_reset();
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.sram_data_out_valid = 1'b1;
        applyStimulus(4'b0000);
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
